// File: rtl/ring_counter_mon_if.sv
// Signal bundle between a one-hot ring counter source and its receive-side monitor.
// The master side drives the ring pattern; the slave side returns decode and status.
interface ring_counter_mon_if #(
  parameter int PW = 16,
  parameter int RW = 8
);
  logic [7:0]    cnt_in;
  logic [2:0]    pos;
  logic          valid;
  logic          dir;
  logic          step;
  logic [PW-1:0] period;
  logic          period_vld;
  logic [RW-1:0] rev_cnt;
  logic          stall;
  logic          err;
  logic [1:0]    err_code;

  modport master (
    output cnt_in,
    input  pos, valid, dir, step, period, period_vld, rev_cnt, stall, err, err_code
  );

  modport slave (
    input  cnt_in,
    output pos, valid, dir, step, period, period_vld, rev_cnt, stall, err, err_code
  );
endinterface

// File: rtl/ring_counter_mon.sv
// Receive-side monitor for an 8-bit one-hot ring counter: decodes position and direction,
// measures step period, counts revolutions and flags protocol violations.
module ring_counter_mon #(
  parameter int PW = 16,
  parameter int RW = 8
) (
  input logic             mclk,
  input logic             rst,
  ring_counter_mon_if.slave mon
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  localparam logic [PW-1:0] PER_MAX  = {PW{1'b1}};
  localparam logic [PW-1:0] PER_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PER_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] REV_ONE  = {{(RW-1){1'b0}}, 1'b1};

  function automatic logic is_onehot(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return (n == 4'd1);
  endfunction

  function automatic logic [2:0] onehot_enc(input logic [7:0] v);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < 8; i++) begin
      p = v[i] ? 3'(i) : p;
    end
    return p;
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, prev_q, prev_d;
  logic [2:0]    pos_q, pos_d;
  logic          valid_q, valid_d;
  logic          dir_q, dir_d;
  logic          step_q, step_d;
  logic [PW-1:0] period_q, period_d;
  logic          period_vld_q, period_vld_d;
  logic [RW-1:0] rev_q, rev_d;
  logic          stall_q, stall_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;

  logic          onehot_s;
  logic [2:0]    new_pos_s;
  logic [2:0]    pos_up_s;
  logic [2:0]    pos_dn_s;
  logic          up_s;
  logic          down_s;
  logic [PW-1:0] per_inc_s;

  assign onehot_s  = is_onehot(cnt_q);
  assign new_pos_s = onehot_enc(cnt_q);
  assign pos_up_s  = pos_q + 3'd1;
  assign pos_dn_s  = pos_q - 3'd1;
  assign up_s      = onehot_s && (new_pos_s == pos_up_s);
  assign down_s    = onehot_s && (new_pos_s == pos_dn_s);
  assign per_inc_s = (per_cnt_q == PER_MAX) ? PER_MAX : (per_cnt_q + PER_ONE);

  // Next-state and output decode from the registered pattern versus the last accepted one.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    pos_d        = pos_q;
    valid_d      = valid_q;
    dir_d        = dir_q;
    step_d       = 1'b0;
    period_d     = period_q;
    period_vld_d = period_vld_q;
    rev_d        = rev_q;
    stall_d      = stall_q;
    err_d        = err_q;
    code_d       = code_q;
    per_cnt_d    = per_cnt_q;

    case (state_q)
      S_IDLE: begin
        per_cnt_d = PER_ZERO;
        if (onehot_s) begin
          pos_d   = new_pos_s;
          prev_d  = cnt_q;
          valid_d = 1'b1;
          state_d = S_ACQ;
        end else begin
          valid_d = 1'b0;
        end
      end
      S_ACQ, S_TRACK: begin
        per_cnt_d = (state_q == S_TRACK) ? per_inc_s : per_cnt_q;
        if (cnt_q == prev_q) begin
          stall_d = (state_q == S_TRACK) && (per_cnt_d == PER_MAX);
        end else if (up_s || down_s) begin
          step_d    = 1'b1;
          pos_d     = new_pos_s;
          prev_d    = cnt_q;
          dir_d     = down_s;
          per_cnt_d = PER_ZERO;
          stall_d   = 1'b0;
          state_d   = S_TRACK;
          // The first move out of S_ACQ has no reference step, so no period yet.
          if (state_q == S_TRACK) begin
            period_d     = per_inc_s;
            period_vld_d = 1'b1;
          end else begin
            period_vld_d = 1'b0;
          end
          if ((up_s && (pos_q == 3'd7)) || (down_s && (pos_q == 3'd0))) begin
            rev_d = rev_q + REV_ONE;
          end else begin
            rev_d = rev_q;
          end
        end else begin
          err_d        = 1'b1;
          code_d       = onehot_s ? 2'b10 : 2'b01;
          valid_d      = 1'b0;
          period_vld_d = 1'b0;
          stall_d      = 1'b0;
          per_cnt_d    = PER_ZERO;
          state_d      = S_IDLE;
        end
      end
      default: begin
        valid_d      = 1'b0;
        period_vld_d = 1'b0;
        stall_d      = 1'b0;
        per_cnt_d    = PER_ZERO;
        state_d      = S_IDLE;
      end
    endcase
  end

  // State, input sample and output registers.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'h00;
      prev_q       <= 8'h00;
      pos_q        <= 3'd0;
      valid_q      <= 1'b0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      period_q     <= PER_ZERO;
      period_vld_q <= 1'b0;
      rev_q        <= {RW{1'b0}};
      stall_q      <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= 2'b00;
      per_cnt_q    <= PER_ZERO;
    end else begin
      state_q      <= state_d;
      cnt_q        <= mon.cnt_in;
      prev_q       <= prev_d;
      pos_q        <= pos_d;
      valid_q      <= valid_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      rev_q        <= rev_d;
      stall_q      <= stall_d;
      err_q        <= err_d;
      code_q       <= code_d;
      per_cnt_q    <= per_cnt_d;
    end
  end

  assign mon.pos        = pos_q;
  assign mon.valid      = valid_q;
  assign mon.dir        = dir_q;
  assign mon.step       = step_q;
  assign mon.period     = period_q;
  assign mon.period_vld = period_vld_q;
  assign mon.rev_cnt    = rev_q;
  assign mon.stall      = stall_q;
  assign mon.err        = err_q;
  assign mon.err_code   = code_q;

endmodule

// File: tb/tb_ring_counter_mon.sv
// Bench for ring_counter_mon: stimulus table with per-row expectations, a cycle scoreboard
// fed by a behavioural model, and directed sequences for stall and asynchronous reset.
module tb_ring_counter_mon;
  localparam int PW = 4;
  localparam int RW = 8;
  localparam int PMAXI = (1 << PW) - 1;

  logic mclk = 1'b0;
  logic rst  = 1'b0;

  ring_counter_mon_if #(.PW(PW), .RW(RW)) bus ();
  ring_counter_mon #(.PW(PW), .RW(RW)) dut (.mclk(mclk), .rst(rst), .mon(bus));

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic          valid;
    logic [2:0]    pos;
    logic          dir;
    logic          step;
    logic [PW-1:0] period;
    logic          period_vld;
    logic [RW-1:0] rev;
    logic          stall;
    logic          err;
    logic [1:0]    code;
  } obs_t;

  typedef struct {
    logic [7:0]    cnt;
    int            hold;
    logic          valid;
    logic [2:0]    pos;
    logic          chk_dir;
    logic          dir;
    logic [RW-1:0] rev;
    logic          err;
    logic [1:0]    code;
  } vec_t;

  obs_t       sbq[$];
  vec_t       vecs[$];
  obs_t       m;
  int         ms;
  logic [7:0] mprev;
  int         mper;
  int         total = 0;
  int         bad   = 0;

  function automatic obs_t sample();
    return {bus.valid, bus.pos, bus.dir, bus.step, bus.period, bus.period_vld,
            bus.rev_cnt, bus.stall, bus.err, bus.err_code};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m     = '0;
    ms    = 0;
    mprev = 8'h00;
    mper  = 0;
    sbq.delete();
  endtask

  // Behavioural reference: consumes the pattern driven this cycle, yields outputs seen two edges later.
  task automatic model(input logic [7:0] x);
    bit oh;
    int np, op, pc;
    oh = ($countones(x) == 1);
    np = oh ? $clog2(x) : 0;
    op = int'(m.pos);
    pc = mper;
    m.step = 1'b0;
    if (ms == 0) begin
      mper = 0;
      if (oh) begin
        m.pos   = 3'(np);
        mprev   = x;
        m.valid = 1'b1;
        ms      = 1;
      end
    end else begin
      if (ms == 2 && mper < PMAXI) mper++;
      if (x != mprev) begin
        if (oh && (np == (op + 1) % 8 || np == (op + 7) % 8)) begin
          m.step  = 1'b1;
          m.dir   = (np == (op + 7) % 8);
          m.pos   = 3'(np);
          mprev   = x;
          mper    = 0;
          m.stall = 1'b0;
          if ((op == 7 && np == 0) || (op == 0 && np == 7)) m.rev = m.rev + 8'd1;
          if (ms == 2) begin
            m.period     = (pc + 1 > PMAXI) ? PW'(PMAXI) : PW'(pc + 1);
            m.period_vld = 1'b1;
          end
          ms = 2;
        end else begin
          m.err        = 1'b1;
          m.code       = oh ? 2'b10 : 2'b01;
          m.valid      = 1'b0;
          m.period_vld = 1'b0;
          m.stall      = 1'b0;
          mper         = 0;
          ms           = 0;
        end
      end else if (ms == 2) begin
        m.stall = (mper == PMAXI);
      end
    end
  endtask

  task automatic tick(input logic [7:0] x);
    obs_t e;
    @(negedge mclk);
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      check("scoreboard", 64'(sample()), 64'(e));
    end
    bus.cnt_in = x;
    model(x);
    sbq.push_back(m);
  endtask

  task automatic add(input logic [7:0] c, input logic v, input logic [2:0] p, input logic cd,
                     input logic d, input logic [RW-1:0] r, input logic e, input logic [1:0] k);
    vec_t t;
    t.cnt = c; t.hold = 4; t.valid = v; t.pos = p; t.chk_dir = cd; t.dir = d;
    t.rev = r; t.err = e; t.code = k;
    vecs.push_back(t);
  endtask

  initial begin
    bus.cnt_in = 8'h00;
    model_reset();

    // Table: lock, a full upward revolution, reversal, then the two error kinds and down wrap.
    add(8'h01, 1'b1, 3'd0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00);
    for (int i = 1; i < 8; i++) add(8'(1 << i), 1'b1, 3'(i), 1'b1, 1'b0, 8'd0, 1'b0, 2'b00);
    add(8'h01, 1'b1, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0, 2'b00);
    add(8'h02, 1'b1, 3'd1, 1'b1, 1'b0, 8'd1, 1'b0, 2'b00);
    add(8'h04, 1'b1, 3'd2, 1'b1, 1'b0, 8'd1, 1'b0, 2'b00);
    add(8'h08, 1'b1, 3'd3, 1'b1, 1'b0, 8'd1, 1'b0, 2'b00);
    add(8'h10, 1'b1, 3'd4, 1'b1, 1'b0, 8'd1, 1'b0, 2'b00);
    add(8'h08, 1'b1, 3'd3, 1'b1, 1'b1, 8'd1, 1'b0, 2'b00);
    add(8'h18, 1'b0, 3'd0, 1'b0, 1'b0, 8'd1, 1'b1, 2'b01);
    add(8'h01, 1'b1, 3'd0, 1'b0, 1'b0, 8'd1, 1'b1, 2'b01);
    add(8'h04, 1'b1, 3'd2, 1'b0, 1'b0, 8'd1, 1'b1, 2'b10);
    add(8'h02, 1'b1, 3'd1, 1'b1, 1'b1, 8'd1, 1'b1, 2'b10);
    add(8'h01, 1'b1, 3'd0, 1'b1, 1'b1, 8'd1, 1'b1, 2'b10);
    add(8'h80, 1'b1, 3'd7, 1'b1, 1'b1, 8'd2, 1'b1, 2'b10);
    add(8'h01, 1'b1, 3'd0, 1'b1, 1'b0, 8'd3, 1'b1, 2'b10);

    #12;
    check("reset_outputs", 64'(sample()), 64'd0);
    @(negedge mclk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].hold; k++) tick(vecs[i].cnt);
      check($sformatf("row%0d_valid", i), 64'(bus.valid), 64'(vecs[i].valid));
      if (vecs[i].valid) check($sformatf("row%0d_pos", i), 64'(bus.pos), 64'(vecs[i].pos));
      if (vecs[i].chk_dir) check($sformatf("row%0d_dir", i), 64'(bus.dir), 64'(vecs[i].dir));
      check($sformatf("row%0d_rev", i), 64'(bus.rev_cnt), 64'(vecs[i].rev));
      check($sformatf("row%0d_err", i), 64'(bus.err), 64'(vecs[i].err));
      check($sformatf("row%0d_code", i), 64'(bus.err_code), 64'(vecs[i].code));
      if (i == 8) check("rev_period", 64'(bus.period), 64'd4);
      if (i == 8) check("rev_period_vld", 64'(bus.period_vld), 64'd1);
    end

    // Asynchronous reset in mid-run with rev_cnt=3 and err=1: outputs clear before any edge.
    #2;
    rst = 1'b0;
    bus.cnt_in = 8'h00;
    #1;
    check("midrun_reset", 64'(sample()), 64'd0);
    model_reset();
    @(negedge mclk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) tick(8'h01);
    check("relock_valid", 64'(bus.valid), 64'd1);
    check("relock_err", 64'(bus.err), 64'd0);
    check("relock_rev", 64'(bus.rev_cnt), 64'd0);

    // Stall: one step, then hold until the period counter saturates.
    for (int k = 0; k < 17; k++) tick(8'h02);
    check("stall_before", 64'(bus.stall), 64'd0);
    tick(8'h02);
    check("stall_set", 64'(bus.stall), 64'd1);
    for (int k = 0; k < 3; k++) tick(8'h04);
    check("stall_step", 64'(bus.step), 64'd1);
    check("stall_period", 64'(bus.period), 64'd15);
    check("stall_clear", 64'(bus.stall), 64'd0);
    for (int k = 0; k < 3; k++) tick(8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
